// File: rtl/wb_commit_cp0_unit_if.sv
// -----------------------------------------------------------------------------
// wb_commit_cp0_unit_if
// Commit bundle between the W stage and the commit/CP0 unit.
//
// lane_* signals carry up to COMMIT_WIDTH in-order W-stage instructions, and
// lane 0 is the oldest. lane_valid alone qualifies a lane; there is no ready.
// The unit accepts every valid lane in the cycle it is presented, except in
// the flush cycle (redirect_valid=1), where presented lanes are dropped.
// redirect_valid is a one-cycle pulse that comes one cycle after the
// terminating commit, and redirect_pc is the fetch target.
//
// Signals (master = W stage, slave = commit unit):
//   lane_*          master -> slave  per-lane instruction fields
//   rf_we/waddr/wdata  slave -> master  GPR write ports (combinational)
//   redirect_valid/pc  slave -> master  registered flush/redirect
// -----------------------------------------------------------------------------
interface wb_commit_cp0_unit_if #(
  parameter int COMMIT_WIDTH = 2
);
  logic [COMMIT_WIDTH-1:0]    lane_valid;
  logic [32*COMMIT_WIDTH-1:0] lane_pc;
  logic [COMMIT_WIDTH-1:0]    lane_delayed;
  logic [COMMIT_WIDTH-1:0]    lane_exc_valid;
  logic [5*COMMIT_WIDTH-1:0]  lane_exc_code;
  logic [32*COMMIT_WIDTH-1:0] lane_bad_vaddr;
  logic [COMMIT_WIDTH-1:0]    lane_exc_badva;
  logic [COMMIT_WIDTH-1:0]    lane_eret;
  logic [COMMIT_WIDTH-1:0]    lane_mtc0;
  logic [COMMIT_WIDTH-1:0]    lane_wr_valid;
  logic [5*COMMIT_WIDTH-1:0]  lane_wr_dst;
  logic [32*COMMIT_WIDTH-1:0] lane_wr_value;
  logic [COMMIT_WIDTH-1:0]    lane_hi_valid;
  logic [COMMIT_WIDTH-1:0]    lane_lo_valid;
  logic [32*COMMIT_WIDTH-1:0] lane_hi;
  logic [32*COMMIT_WIDTH-1:0] lane_lo;
  logic [COMMIT_WIDTH-1:0]    rf_we;
  logic [5*COMMIT_WIDTH-1:0]  rf_waddr;
  logic [32*COMMIT_WIDTH-1:0] rf_wdata;
  logic                       redirect_valid;
  logic [31:0]                redirect_pc;

  modport master (
    output lane_valid, lane_pc, lane_delayed, lane_exc_valid, lane_exc_code,
           lane_bad_vaddr, lane_exc_badva, lane_eret, lane_mtc0, lane_wr_valid,
           lane_wr_dst, lane_wr_value, lane_hi_valid, lane_lo_valid, lane_hi, lane_lo,
    input  rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc
  );

  modport slave (
    input  lane_valid, lane_pc, lane_delayed, lane_exc_valid, lane_exc_code,
           lane_bad_vaddr, lane_exc_badva, lane_eret, lane_mtc0, lane_wr_valid,
           lane_wr_dst, lane_wr_value, lane_hi_valid, lane_lo_valid, lane_hi, lane_lo,
    output rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/wb_commit_cp0_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_cp0_unit
// Commits up to COMMIT_WIDTH in-order W-stage instructions per cycle. Owns the
// GPR write ports, HI/LO and CP0 (Status, Cause, EPC, BadVAddr, Count,
// Compare, ErrorEPC), arbitrates exceptions / interrupts / ERET and drives a
// registered redirect to fetch.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   commitBus    commit bundle in, GPR writes and redirect out (slave modport)
//   ext_int      level-sensitive hardware interrupt lines
//   cp0_rsel     CP0 read select; cp0_rdata returns registered (pre-commit) state
//   hi, lo       architectural HI / LO
//
// Optional feature macro: WB_CP0_TIMER_EN enables the Count/Compare timer and
// its TI merge into Cause.IP[7]. Without it Count/Compare read 0, MTC0 to
// them is ignored and TI is 0.
// -----------------------------------------------------------------------------
module wb_commit_cp0_unit #(
  parameter int          COMMIT_WIDTH = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0004,
  parameter logic [31:0] EXC_VEC_BEV  = 32'hbfc0_0380,
  parameter logic [31:0] EXC_VEC_NORM = 32'h8000_0180
) (
  input  logic                clk,
  input  logic                reset,
  wb_commit_cp0_unit_if.slave commitBus,
  input  logic [5:0]          ext_int,
  input  logic [4:0]          cp0_rsel,
  output logic [31:0]         cp0_rdata,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);
  localparam int W = COMMIT_WIDTH;

  // Architectural state
  logic [31:0] statusReg, epcReg, badVAddrReg, errorEpcReg, hiReg, loReg;
  logic        causeBd;
  logic [7:0]  causeIp;
  logic [4:0]  causeExc;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] countReg, compareReg;
  logic        tiReg;

`ifdef WB_CP0_TIMER_EN
  logic        toggleReg, toggleNext;
  logic [31:0] countNext, compareNext;
  logic        tiNext, countWritten, compareWritten;
`else
  assign countReg   = '0;
  assign compareReg = '0;
  assign tiReg      = 1'b0;
`endif

  // Per-lane field views
  logic [31:0] lanePc [W];
  logic [31:0] laneBadVa [W];
  logic [31:0] laneWrValue [W];
  logic [31:0] laneHi [W];
  logic [31:0] laneLo [W];
  logic [4:0]  laneExcCode [W];
  logic [4:0]  laneDst [W];

  for (genvar g = 0; g < W; g++) begin : g_lane
    assign lanePc[g]      = commitBus.lane_pc[32*g +: 32];
    assign laneBadVa[g]   = commitBus.lane_bad_vaddr[32*g +: 32];
    assign laneWrValue[g] = commitBus.lane_wr_value[32*g +: 32];
    assign laneHi[g]      = commitBus.lane_hi[32*g +: 32];
    assign laneLo[g]      = commitBus.lane_lo[32*g +: 32];
    assign laneExcCode[g] = commitBus.lane_exc_code[5*g +: 5];
    assign laneDst[g]     = commitBus.lane_wr_dst[5*g +: 5];
  end

  // Lanes presented during reset or in the flush cycle have no effect.
  logic [W-1:0] laneLive;
  assign laneLive = (reset || redirectValid) ? '0 : commitBus.lane_valid;

  logic intTaken;
  assign intTaken = laneLive[0] && (|(causeIp & statusReg[15:8])) &&
                    statusReg[0] && !statusReg[1] && !statusReg[2];

  // Commit scan: first live lane with interrupt/exception/ERET terminates;
  // lanes before it commit, it and all younger lanes are killed.
  logic [W-1:0] committed;
  logic         termFound, termIsExc, termDelayed, termBadvaEn;
  logic [4:0]   termCode;
  logic [31:0]  termPc, termBadVa;

  always_comb begin
    committed   = '0;
    termFound   = 1'b0;
    termIsExc   = 1'b0;
    termDelayed = 1'b0;
    termBadvaEn = 1'b0;
    termCode    = '0;
    termPc      = '0;
    termBadVa   = '0;
    for (int i = 0; i < W; i++) begin
      if (laneLive[i] && !termFound) begin
        if (i == 0 && intTaken) begin
          // Interrupt overrides any lane-0 exception, so no BadVAddr write.
          termFound   = 1'b1;
          termIsExc   = 1'b1;
          termCode    = 5'd0;
          termPc      = lanePc[i];
          termDelayed = commitBus.lane_delayed[i];
        end else if (commitBus.lane_exc_valid[i]) begin
          termFound   = 1'b1;
          termIsExc   = 1'b1;
          termCode    = laneExcCode[i];
          termPc      = lanePc[i];
          termDelayed = commitBus.lane_delayed[i];
          termBadvaEn = commitBus.lane_exc_badva[i];
          termBadVa   = laneBadVa[i];
        end else if (commitBus.lane_eret[i]) begin
          termFound = 1'b1;
        end else begin
          committed[i] = 1'b1;
        end
      end
    end
  end

  // GPR write enables; on a shared destination only the youngest lane writes.
  logic [W-1:0] rfCand, rfWe;
  always_comb begin
    rfCand = '0;
    rfWe   = '0;
    for (int i = 0; i < W; i++) begin
      rfCand[i] = committed[i] && commitBus.lane_wr_valid[i] &&
                  !commitBus.lane_mtc0[i] && (laneDst[i] != 5'd0);
    end
    for (int i = 0; i < W; i++) begin
      rfWe[i] = rfCand[i];
      for (int j = 0; j < W; j++) begin
        if (j > i && rfCand[j] && laneDst[j] == laneDst[i]) rfWe[i] = 1'b0;
      end
    end
  end

  assign commitBus.rf_we          = rfWe;
  assign commitBus.rf_waddr       = commitBus.lane_wr_dst;
  assign commitBus.rf_wdata       = commitBus.lane_wr_value;
  assign commitBus.redirect_valid = redirectValid;
  assign commitBus.redirect_pc    = redirectPc;

  // Next-state: per-cycle updates, then MTC0/HI/LO in lane order, then the
  // terminating event (which is youngest of all effects in program order).
  logic [31:0] statusNext, epcNext, badVAddrNext, errorEpcNext, hiNext, loNext;
  logic [31:0] redirectPcNext;
  logic        causeBdNext;
  logic [4:0]  causeExcNext;
  logic [1:0]  causeIpSwNext;

  always_comb begin
    statusNext     = statusReg;
    epcNext        = epcReg;
    badVAddrNext   = badVAddrReg;
    errorEpcNext   = errorEpcReg;
    hiNext         = hiReg;
    loNext         = loReg;
    causeBdNext    = causeBd;
    causeExcNext   = causeExc;
    causeIpSwNext  = causeIp[1:0];
    redirectPcNext = redirectPc;
`ifdef WB_CP0_TIMER_EN
    toggleNext     = !toggleReg;
    countNext      = toggleReg ? countReg + 32'd1 : countReg;
    compareNext    = compareReg;
    countWritten   = 1'b0;
    compareWritten = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
      if (committed[i]) begin
        if (commitBus.lane_hi_valid[i]) hiNext = laneHi[i];
        if (commitBus.lane_lo_valid[i]) loNext = laneLo[i];
        if (commitBus.lane_wr_valid[i] && commitBus.lane_mtc0[i]) begin
          case (laneDst[i])
            5'd8:  badVAddrNext = laneWrValue[i];
`ifdef WB_CP0_TIMER_EN
            5'd9: begin
              countNext    = laneWrValue[i];
              countWritten = 1'b1;
            end
            5'd11: begin
              compareNext    = laneWrValue[i];
              compareWritten = 1'b1;
            end
`endif
            5'd12: statusNext    = laneWrValue[i];
            5'd13: causeIpSwNext = laneWrValue[i][9:8];
            5'd14: epcNext       = laneWrValue[i];
            5'd30: errorEpcNext  = laneWrValue[i];
            default: ;
          endcase
        end
      end
    end
`ifdef WB_CP0_TIMER_EN
    // Match only on a real increment; a Compare write always leaves TI clear.
    tiNext = compareWritten ? 1'b0 :
             (tiReg | (toggleReg && !countWritten && (countReg + 32'd1 == compareReg)));
`endif
    if (termFound) begin
      if (termIsExc) begin
        if (!statusNext[1]) begin
          epcNext     = termDelayed ? termPc - 32'd4 : termPc;
          causeBdNext = termDelayed;
        end
        statusNext[1] = 1'b1;
        causeExcNext  = termCode;
        if (termBadvaEn) badVAddrNext = termBadVa;
        redirectPcNext = statusNext[22] ? EXC_VEC_BEV : EXC_VEC_NORM;
      end else if (statusNext[2]) begin
        statusNext[2]  = 1'b0;
        redirectPcNext = errorEpcNext;
      end else begin
        statusNext[1]  = 1'b0;
        redirectPcNext = epcNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      statusReg     <= RESET_STATUS;
      epcReg        <= '0;
      badVAddrReg   <= '0;
      errorEpcReg   <= '0;
      hiReg         <= '0;
      loReg         <= '0;
      causeBd       <= 1'b0;
      causeIp       <= '0;
      causeExc      <= '0;
      redirectValid <= 1'b0;
      redirectPc    <= '0;
`ifdef WB_CP0_TIMER_EN
      toggleReg     <= 1'b0;
      countReg      <= '0;
      compareReg    <= '0;
      tiReg         <= 1'b0;
`endif
    end else begin
      statusReg     <= statusNext;
      epcReg        <= epcNext;
      badVAddrReg   <= badVAddrNext;
      errorEpcReg   <= errorEpcNext;
      hiReg         <= hiNext;
      loReg         <= loNext;
      causeBd       <= causeBdNext;
      causeIp       <= {tiReg | ext_int[5], ext_int[4:0], causeIpSwNext};
      causeExc      <= causeExcNext;
      redirectValid <= termFound;
      redirectPc    <= redirectPcNext;
`ifdef WB_CP0_TIMER_EN
      toggleReg     <= toggleNext;
      countReg      <= countNext;
      compareReg    <= compareNext;
      tiReg         <= tiNext;
`endif
    end
  end

  always_comb begin
    case (cp0_rsel)
      5'd8:    cp0_rdata = badVAddrReg;
      5'd9:    cp0_rdata = countReg;
      5'd11:   cp0_rdata = compareReg;
      5'd12:   cp0_rdata = statusReg;
      5'd13:   cp0_rdata = {causeBd, tiReg, 14'd0, causeIp, 1'b0, causeExc, 2'b00};
      5'd14:   cp0_rdata = epcReg;
      5'd30:   cp0_rdata = errorEpcReg;
      default: cp0_rdata = '0;
    endcase
  end

  assign hi = hiReg;
  assign lo = loReg;
endmodule

// File: tb/tb_wb_commit_cp0_unit.sv
module tb_wb_commit_cp0_unit;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  extInt;
  logic [4:0]  cp0Rsel;
  logic [31:0] cp0Rdata, hiOut, loOut;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  logic [31:0] exp_q[$];

  wb_commit_cp0_unit_if #(.COMMIT_WIDTH(W)) bus ();

  wb_commit_cp0_unit #(.COMMIT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .commitBus (bus),
    .ext_int   (extInt),
    .cp0_rsel  (cp0Rsel),
    .cp0_rdata (cp0Rdata),
    .hi        (hiOut),
    .lo        (loOut)
  );

  // clock / reset
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic clearLanes();
    bus.lane_valid     = '0;
    bus.lane_pc        = '0;
    bus.lane_delayed   = '0;
    bus.lane_exc_valid = '0;
    bus.lane_exc_code  = '0;
    bus.lane_bad_vaddr = '0;
    bus.lane_exc_badva = '0;
    bus.lane_eret      = '0;
    bus.lane_mtc0      = '0;
    bus.lane_wr_valid  = '0;
    bus.lane_wr_dst    = '0;
    bus.lane_wr_value  = '0;
    bus.lane_hi_valid  = '0;
    bus.lane_lo_valid  = '0;
    bus.lane_hi        = '0;
    bus.lane_lo        = '0;
  endtask

  task automatic laneWrite(input int i, input logic [4:0] dst, input logic [31:0] val,
                           input logic mtc0);
    bus.lane_valid[i]             = 1'b1;
    bus.lane_pc[32*i +: 32]       = 32'h8000_0400 + 32'(i * 4);
    bus.lane_wr_valid[i]          = 1'b1;
    bus.lane_mtc0[i]              = mtc0;
    bus.lane_wr_dst[5*i +: 5]     = dst;
    bus.lane_wr_value[32*i +: 32] = val;
  endtask

  task automatic laneHiLo(input int i, input logic hiEn, input logic [31:0] hiVal,
                          input logic loEn, input logic [31:0] loVal);
    bus.lane_valid[i]       = 1'b1;
    bus.lane_hi_valid[i]    = hiEn;
    bus.lane_hi[32*i +: 32] = hiVal;
    bus.lane_lo_valid[i]    = loEn;
    bus.lane_lo[32*i +: 32] = loVal;
  endtask

  task automatic laneExc(input int i, input logic [31:0] pc, input logic [4:0] code,
                         input logic delayed, input logic badvaEn, input logic [31:0] badVa);
    bus.lane_valid[i]              = 1'b1;
    bus.lane_pc[32*i +: 32]        = pc;
    bus.lane_delayed[i]            = delayed;
    bus.lane_exc_valid[i]          = 1'b1;
    bus.lane_exc_code[5*i +: 5]    = code;
    bus.lane_exc_badva[i]          = badvaEn;
    bus.lane_bad_vaddr[32*i +: 32] = badVa;
  endtask

  task automatic laneEret(input int i, input logic [31:0] pc);
    bus.lane_valid[i]       = 1'b1;
    bus.lane_pc[32*i +: 32] = pc;
    bus.lane_eret[i]        = 1'b1;
  endtask

  task automatic readCp0(input logic [4:0] sel, output logic [31:0] val);
    cp0Rsel = sel;
    #1;
    val = cp0Rdata;
  endtask

  task automatic checkCp0(input string tag, input logic [4:0] sel, input logic [31:0] expv);
    logic [31:0] v;
    readCp0(sel, v);
    check(tag, v, expv);
  endtask

  task automatic checkRfWe(input string tag, input logic [W-1:0] expv);
    #1;
    check(tag, 32'(bus.rf_we), 32'(expv));
  endtask

  // Advance one clock; the scoreboard matches each redirect pulse against
  // the target queued when the terminating bundle was driven.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0 || bus.redirect_valid !== 1'b0) begin
      check("redirect_valid", 32'(bus.redirect_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bus.redirect_valid === 1'b1) check("redirect_pc", bus.redirect_pc, e);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic        found;

    reset   = 1'b1;
    extInt  = '0;
    cp0Rsel = '0;
    clearLanes();
    repeat (2) @(posedge clk);
    #1;
    check("reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("reset_redirect_pc", bus.redirect_pc, 32'd0);
    checkCp0("reset_status", 5'd12, 32'h0040_0004);
    checkCp0("reset_cause", 5'd13, 32'd0);
    checkCp0("reset_epc", 5'd14, 32'd0);
    check("reset_hi", hiOut, 32'd0);
    check("reset_lo", loOut, 32'd0);
    reset = 1'b0;
    step();

    // Dual commit to the same GPR plus HI/LO: youngest wins
    laneWrite(0, 5'd3, 32'd5, 1'b0);
    laneWrite(1, 5'd3, 32'd7, 1'b0);
    laneHiLo(0, 1'b1, 32'h11, 1'b1, 32'h33);
    laneHiLo(1, 1'b1, 32'h22, 1'b0, 32'h44);
    checkRfWe("dual_same_dst_we", 2'b10);
    check("dual_waddr1", 32'(bus.rf_waddr[9:5]), 32'd3);
    check("dual_wdata1", bus.rf_wdata[63:32], 32'd7);
    step();
    clearLanes();
    check("hi_youngest", hiOut, 32'h22);
    check("lo_only_writer", loOut, 32'h33);

    // Destination $0 never written
    laneWrite(0, 5'd5, 32'd9, 1'b0);
    laneWrite(1, 5'd0, 32'd1, 1'b0);
    checkRfWe("dst_zero_we", 2'b01);
    step();
    clearLanes();

    // AdEL in a delay slot on lane 0; lane 1 killed
    laneExc(0, 32'hbfc0_0100, 5'd4, 1'b1, 1'b1, 32'h1);
    laneWrite(1, 5'd4, 32'h44, 1'b0);
    laneHiLo(1, 1'b1, 32'h99, 1'b0, 32'h0);
    checkRfWe("adel_kill_we", 2'b00);
    exp_q.push_back(32'hbfc0_0380);
    step();
    clearLanes();
    checkCp0("adel_epc", 5'd14, 32'hbfc0_00fc);
    checkCp0("adel_cause", 5'd13, 32'h8000_0010);
    checkCp0("adel_badvaddr", 5'd8, 32'h1);
    checkCp0("adel_status", 5'd12, 32'h0040_0006);
    check("adel_hi_kept", hiOut, 32'h22);
    // Lanes presented in the flush cycle are dropped
    laneWrite(0, 5'd14, 32'hdead, 1'b1);
    laneWrite(1, 5'd6, 32'd1, 1'b0);
    checkRfWe("flush_cycle_we", 2'b00);
    step();
    clearLanes();
    checkCp0("flush_epc_kept", 5'd14, 32'hbfc0_00fc);

    // Enable interrupts, then raise ext_int[0]
    laneWrite(0, 5'd12, 32'h0000_ff01, 1'b1);
    step();
    clearLanes();
    checkCp0("status_mtc0", 5'd12, 32'h0000_ff01);
    extInt = 6'b000001;
    step();
    laneWrite(0, 5'd9, 32'd0, 1'b0);
    bus.lane_wr_valid[0] = 1'b0;
    bus.lane_pc[31:0] = 32'h8000_1000;
    laneWrite(1, 5'd7, 32'd1, 1'b0);
    checkRfWe("int_kill_we", 2'b00);
    exp_q.push_back(32'h8000_0180);
    step();
    clearLanes();
    extInt = '0;
    checkCp0("int_cause", 5'd13, 32'h0000_0400);
    checkCp0("int_epc", 5'd14, 32'h8000_1000);
    checkCp0("int_status", 5'd12, 32'h0000_ff03);
    step();
    step();

    // Exception with EXL already set: EPC kept, ExcCode updated
    laneExc(0, 32'h8000_2000, 5'd12, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h8000_0180);
    step();
    clearLanes();
    checkCp0("exl_epc_kept", 5'd14, 32'h8000_1000);
    checkCp0("exl_cause", 5'd13, 32'h0000_0030);
    step();

    // ERET with ERL=0 returns to EPC and clears EXL; lane 1 killed
    laneEret(0, 32'h8000_3000);
    laneWrite(1, 5'd8, 32'd3, 1'b0);
    checkRfWe("eret_kill_we", 2'b00);
    exp_q.push_back(32'h8000_1000);
    step();
    clearLanes();
    checkCp0("eret_status", 5'd12, 32'h0000_ff01);
    step();

    // ERL path, MTC0 ordering, Cause write mask
    laneWrite(0, 5'd12, 32'h0000_0004, 1'b1);
    laneWrite(1, 5'd30, 32'h9000_0000, 1'b1);
    step();
    clearLanes();
    checkCp0("errorepc_mtc0", 5'd30, 32'h9000_0000);
    laneWrite(0, 5'd14, 32'h1111, 1'b1);
    laneWrite(1, 5'd14, 32'h2222, 1'b1);
    step();
    clearLanes();
    checkCp0("mtc0_youngest", 5'd14, 32'h2222);
    laneEret(0, 32'h8000_3000);
    exp_q.push_back(32'h9000_0000);
    step();
    clearLanes();
    checkCp0("erl_eret_status", 5'd12, 32'h0000_0000);
    step();
    laneWrite(0, 5'd13, 32'hffff_ffff, 1'b1);
    laneWrite(1, 5'd15, 32'h5555, 1'b1);
    step();
    clearLanes();
    checkCp0("cause_mask", 5'd13, 32'h0000_0330);

    // Timer
    laneWrite(0, 5'd9, 32'd0, 1'b1);
    laneWrite(1, 5'd11, 32'd4, 1'b1);
    step();
    clearLanes();
`ifdef WB_CP0_TIMER_EN
    checkCp0("compare_mtc0", 5'd11, 32'd4);
    repeat (6) step();
    readCp0(5'd13, v);
    check("ti_early", 32'(v[30]), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      step();
      readCp0(5'd13, v);
      if (v[30]) found = 1'b1;
    end
    check("ti_set", 32'(found), 32'd1);
    step();
    readCp0(5'd13, v);
    check("ip7_from_ti", 32'(v[15]), 32'd1);
    laneWrite(0, 5'd11, 32'd100, 1'b1);
    step();
    clearLanes();
    readCp0(5'd13, v);
    check("ti_cleared", 32'(v[30]), 32'd0);
`else
    found = 1'b0;
    checkCp0("count_disabled", 5'd9, 32'd0);
    checkCp0("compare_disabled", 5'd11, 32'd0);
    repeat (10) step();
    readCp0(5'd13, v);
    check("ti_disabled", 32'(v[30]), 32'(found));
    check("ip7_disabled", 32'(v[15]), 32'd0);
`endif

    // Reset in the cycle of a lane-0 exception
    laneExc(0, 32'h8000_4000, 5'd10, 1'b0, 1'b0, 32'h0);
    laneWrite(1, 5'd9, 32'd1, 1'b0);
    reset = 1'b1;
    checkRfWe("reset_bundle_we", 2'b00);
    step();
    check("reset_bundle_no_redirect", 32'(bus.redirect_valid), 32'd0);
    reset = 1'b0;
    clearLanes();
    step();
    check("post_reset_no_redirect", 32'(bus.redirect_valid), 32'd0);
    checkCp0("post_reset_status", 5'd12, 32'h0040_0004);
    checkCp0("post_reset_epc", 5'd14, 32'd0);
    check("post_reset_hi", hiOut, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
